// File: rtl/mem_access_unit.sv
// mem_access_unit: RV32I load/store unit for a single-port word memory.
// Handles byte/half/word access, sign extension and read-modify-write.
module mem_access_unit #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE, ACCESS, MERGE, RESP
  } state_t;

  localparam logic [31:0] LIMIT = 32'(4 * MEM_WORDS);

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  state_t      state, nxt;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic        err_q;

  logic        accept;
  logic        bad;
  logic        sub_st;
  logic [31:0] shifted;
  logic [15:0] half;
  logic [31:0] ld_val;
  logic [31:0] merged;

  assign accept = req_valid && (state == IDLE);
  assign sub_st = we_q && (f3_q != F_W);

  // Reject illegal width codes, misalignment and out-of-range addresses
  always_comb begin
    bad = 1'b0;
    unique case (req_funct3)
      F_B:  bad = 1'b0;
      F_H:  bad = req_addr[0];
      F_W:  bad = |req_addr[1:0];
      F_BU: bad = req_we;
      F_HU: bad = req_we | req_addr[0];
      default: bad = 1'b1;
    endcase
    if (req_addr >= LIMIT) bad = 1'b1;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  // Request fields latched on accept; memory word captured in ACCESS
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
      word_q  <= 32'h0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= bad;
      end
      if (state == ACCESS) word_q <= mem_rdata;
    end
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (accept) nxt = bad ? RESP : ACCESS;
      ACCESS:  nxt = sub_st ? MERGE : RESP;
      MERGE:   nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Lane select and extension of the captured load word
  always_comb begin
    shifted = word_q >> {addr_q[1:0], 3'b000};
    half    = addr_q[1] ? word_q[31:16] : word_q[15:0];
    unique case (f3_q)
      F_B:  ld_val = {{24{shifted[7]}}, shifted[7:0]};
      F_BU: ld_val = {24'h0, shifted[7:0]};
      F_H:  ld_val = {{16{half[15]}}, half};
      F_HU: ld_val = {16'h0, half};
      default: ld_val = word_q;
    endcase
  end

  // Replace only the addressed byte or half of the old word
  always_comb begin
    merged = word_q;
    if (f3_q == F_B) begin
      unique case (addr_q[1:0])
        2'd0: merged[7:0]   = wdata_q[7:0];
        2'd1: merged[15:8]  = wdata_q[7:0];
        2'd2: merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else begin
      if (addr_q[1]) merged[31:16] = wdata_q[15:0];
      else           merged[15:0]  = wdata_q[15:0];
    end
  end

  // Output decode per state
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = 32'h0;
    rsp_err   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    unique case (state)
      IDLE: req_ready = 1'b1;
      ACCESS: begin
        mem_addr = {addr_q[31:2], 2'b00};
        if (we_q && f3_q == F_W) begin
          mem_we    = 1'b1;
          mem_wdata = wdata_q;
        end
      end
      MERGE: begin
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_we    = 1'b1;
        mem_wdata = merged;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        if (!err_q && !we_q) rsp_rdata = ld_val;
      end
      default: req_ready = 1'b0;
    endcase
  end

endmodule
